// File: rtl/wt_pkg.sv
// Shared definitions for the wavetable capture and playback blocks.
// Holds the state encoding and the default table geometry.
package wt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REC  = 2'd1,
      DONE = 2'd2
   } wt_state_t;

   localparam int WT_SAMPLE_W = 1;
   localparam int WT_DEPTH    = 32;

endpackage

// File: rtl/wt_sync_edge.sv
// Two-flop synchroniser for an asynchronous button level, followed by an
// edge register that yields single-cycle rise and fall pulses.
module wt_sync_edge (
   input  logic CLK,
   input  logic RST_N,
   input  logic async_in,
   output logic rise,
   output logic fall
);

   logic meta_q;
   logic sync_q;
   logic edge_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         edge_q <= 1'b0;
      end else begin
         meta_q <= async_in;
         sync_q <= meta_q;
         edge_q <= sync_q;
      end
   end

   assign rise = sync_q & ~edge_q;
   assign fall = ~sync_q & edge_q;

endmodule

// File: rtl/wavetable_recorder.sv
// Records strobed microphone samples into a wavetable while Record is held,
// in one-shot or circular mode, with a registered read port for playback.
module wavetable_recorder
   import wt_pkg::*;
#(
   parameter int SAMPLE_W = WT_SAMPLE_W,
   parameter int DEPTH    = WT_DEPTH,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int LOOP     = 0
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                Record,
   input  logic [SAMPLE_W-1:0] Mic_In,
   input  logic                Sample_En,
   input  logic [ADDR_W-1:0]   Rd_Addr,
   output logic [SAMPLE_W-1:0] Rd_Data,
   output logic                Busy,
   output logic                Done,
   output logic                Wrapped,
   output logic [ADDR_W:0]     Count
);

   localparam int CNT_W = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);

   wt_state_t state_q, state_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]    count_d;
   logic                wrapped_d;
   logic                do_write;
   logic                rec_rise;
   logic                rec_fall;
   logic [SAMPLE_W-1:0] mem [DEPTH];

   wt_sync_edge u_record_sync (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .async_in (Record),
      .rise     (rec_rise),
      .fall     (rec_fall)
   );

   // A sample landing on the same edge as the stop request is still stored.
   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = Count;
      wrapped_d = Wrapped;
      do_write  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (rec_rise) begin
               state_d   = REC;
               wr_ptr_d  = '0;
               count_d   = '0;
               wrapped_d = 1'b0;
            end
         end
         REC: begin
            if (Sample_En) begin
               do_write = 1'b1;
               if (Count != FULL_COUNT) begin
                  count_d = Count + 1'b1;
               end
               if (wr_ptr_q == LAST_ADDR) begin
                  wr_ptr_d = '0;
                  if (LOOP != 0) begin
                     wrapped_d = 1'b1;
                  end else begin
                     state_d = DONE;
                  end
               end else begin
                  wr_ptr_d = wr_ptr_q + 1'b1;
               end
            end
            if (rec_fall) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Busy and Done come straight from flops so playback never sees a glitch.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         Count    <= '0;
         Wrapped  <= 1'b0;
         Busy     <= 1'b0;
         Done     <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         Count    <= count_d;
         Wrapped  <= wrapped_d;
         Busy     <= (state_d == REC);
         Done     <= (state_d == DONE);
      end
   end

   always_ff @(posedge CLK) begin
      if (do_write) begin
         mem[wr_ptr_q] <= Mic_In;
      end
   end

   // Read-first; addresses past the table end read as zero.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         Rd_Data <= '0;
      end else if ({1'b0, Rd_Addr} < FULL_COUNT) begin
         Rd_Data <= mem[Rd_Addr];
      end else begin
         Rd_Data <= '0;
      end
   end

endmodule

// File: tb/tb_wavetable_recorder.sv
// Scoreboard bench: one-shot and loop recorders at DEPTH 8, plus a DEPTH 6
// one-shot instance for out-of-range reads, all sharing one stimulus stream.
module tb_wavetable_recorder;

   logic       CLK       = 1'b0;
   logic       RST_N     = 1'b1;
   logic       Record    = 1'b0;
   logic       Sample_En = 1'b0;
   logic [3:0] Mic_In    = '0;
   logic [2:0] Rd_Addr   = '0;

   logic [3:0] rdA, rdB, rdC;
   logic       busyA, busyB, busyC;
   logic       doneA, doneB, doneC;
   logic       wrapA, wrapB, wrapC;
   logic [3:0] cntA, cntB, cntC;

   int          checks = 0;
   int          errors = 0;
   int unsigned cycle  = 0;

   typedef struct {
      string       tag;
      int          dut;
      logic [3:0]  exp;
      int unsigned due;
   } rd_exp_t;

   rd_exp_t readQ[$];

   wavetable_recorder #(.SAMPLE_W(4), .DEPTH(8), .LOOP(0)) dutOneShot (
      .CLK(CLK), .RST_N(RST_N), .Record(Record), .Mic_In(Mic_In),
      .Sample_En(Sample_En), .Rd_Addr(Rd_Addr), .Rd_Data(rdA),
      .Busy(busyA), .Done(doneA), .Wrapped(wrapA), .Count(cntA)
   );

   wavetable_recorder #(.SAMPLE_W(4), .DEPTH(8), .LOOP(1)) dutLoop (
      .CLK(CLK), .RST_N(RST_N), .Record(Record), .Mic_In(Mic_In),
      .Sample_En(Sample_En), .Rd_Addr(Rd_Addr), .Rd_Data(rdB),
      .Busy(busyB), .Done(doneB), .Wrapped(wrapB), .Count(cntB)
   );

   wavetable_recorder #(.SAMPLE_W(4), .DEPTH(6), .LOOP(0)) dutShort (
      .CLK(CLK), .RST_N(RST_N), .Record(Record), .Mic_In(Mic_In),
      .Sample_En(Sample_En), .Rd_Addr(Rd_Addr), .Rd_Data(rdC),
      .Busy(busyC), .Done(doneC), .Wrapped(wrapC), .Count(cntC)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cycle <= cycle + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Pops read expectations once the DUT's registered read data is due.
   always @(negedge CLK) begin
      rd_exp_t e;
      while (readQ.size() > 0 && readQ[0].due <= cycle) begin
         e = readQ.pop_front();
         case (e.dut)
            0:       checkOutput(e.tag, 32'(rdA), 32'(e.exp));
            1:       checkOutput(e.tag, 32'(rdB), 32'(e.exp));
            default: checkOutput(e.tag, 32'(rdC), 32'(e.exp));
         endcase
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] value);
      Mic_In    = value;
      Sample_En = 1'b1;
      tick();
      Sample_En = 1'b0;
   endtask

   task automatic expectRead(input string tag, input logic [2:0] addr,
                             input int dut, input logic [3:0] exp);
      rd_exp_t e;
      Rd_Addr = addr;
      e.tag = tag;
      e.dut = dut;
      e.exp = exp;
      e.due = cycle + 1;
      readQ.push_back(e);
   endtask

   task automatic raiseRecord();
      Record = 1'b1;
      repeat (3) tick();
   endtask

   task automatic dropRecord();
      Record = 1'b0;
      repeat (3) tick();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset state
      #1 RST_N = 1'b0;
      #2;
      checkOutput("rst_busy", 32'(busyA), 0);
      checkOutput("rst_done", 32'(doneA), 0);
      checkOutput("rst_wrap", 32'(wrapB), 0);
      checkOutput("rst_count", 32'(cntA), 0);
      checkOutput("rst_rd", 32'(rdA), 0);
      tick();
      tick();
      RST_N = 1'b1;
      tick();

      // One-shot fill with 10 samples
      Record = 1'b1;
      tick();
      tick();
      checkOutput("rise_edge2_busy", 32'(busyA), 0);
      tick();
      checkOutput("rise_edge3_busy", 32'(busyA), 1);
      checkOutput("rise_edge3_count", 32'(cntA), 0);
      for (int v = 1; v <= 10; v++) begin
         applyStimulus(4'(v));
         if (v == 6) begin
            checkOutput("short_full_done", 32'(doneC), 1);
            checkOutput("short_full_count", 32'(cntC), 6);
         end
         if (v == 7) begin
            checkOutput("os_7_done", 32'(doneA), 0);
            checkOutput("os_7_count", 32'(cntA), 7);
         end
         if (v == 8) begin
            checkOutput("os_8_done", 32'(doneA), 1);
            checkOutput("os_8_busy", 32'(busyA), 0);
            checkOutput("os_8_count", 32'(cntA), 8);
         end
      end
      checkOutput("os_10_count", 32'(cntA), 8);
      checkOutput("loop_10_count", 32'(cntB), 8);
      checkOutput("loop_10_wrap", 32'(wrapB), 1);
      checkOutput("loop_10_busy", 32'(busyB), 1);
      for (int i = 0; i < 8; i++) begin
         expectRead("os_mem", 3'(i), 0, 4'(i + 1));
         expectRead("loop10_mem", 3'(i), 1, (i < 2) ? 4'(i + 9) : 4'(i + 1));
         tick();
      end
      Record = 1'b0;
      tick();
      tick();
      checkOutput("loop_fall_edge2_busy", 32'(busyB), 1);
      tick();
      checkOutput("loop_fall_done", 32'(doneB), 1);
      checkOutput("loop_fall_wrap", 32'(wrapB), 1);
      checkOutput("loop_fall_count", 32'(cntB), 8);

      // Early stop after three samples
      raiseRecord();
      checkOutput("rearm_busy", 32'(busyA), 1);
      checkOutput("rearm_done", 32'(doneA), 0);
      checkOutput("rearm_count", 32'(cntA), 0);
      checkOutput("rearm_wrap", 32'(wrapB), 0);
      applyStimulus(4'hA);
      applyStimulus(4'hB);
      applyStimulus(4'hC);
      Record = 1'b0;
      tick();
      tick();
      checkOutput("early_edge2_done", 32'(doneA), 0);
      checkOutput("early_edge2_busy", 32'(busyA), 1);
      tick();
      checkOutput("early_done", 32'(doneA), 1);
      checkOutput("early_count", 32'(cntA), 3);
      expectRead("early_rdC", 3'd2, 0, 4'hC);
      tick();
      expectRead("early_rdOld", 3'd3, 0, 4'h4);
      tick();

      // Loop mode, 11 samples
      raiseRecord();
      for (int v = 1; v <= 11; v++) begin
         applyStimulus(4'(v));
         if (v == 7) checkOutput("loop_7_wrap", 32'(wrapB), 0);
         if (v == 8) begin
            checkOutput("loop_8_wrap", 32'(wrapB), 1);
            checkOutput("loop_8_busy", 32'(busyB), 1);
            checkOutput("loop_8_count", 32'(cntB), 8);
         end
      end
      dropRecord();
      checkOutput("loop_end_wrap", 32'(wrapB), 1);
      checkOutput("loop_end_count", 32'(cntB), 8);
      checkOutput("loop_end_done", 32'(doneB), 1);
      for (int i = 0; i < 8; i++) begin
         expectRead("loop11_mem", 3'(i), 1, (i < 3) ? 4'(i + 9) : 4'(i + 1));
         expectRead("os2_mem", 3'(i), 0, 4'(i + 1));
         tick();
      end

      // Sample on the same edge as the synchronised fall, read-first collision
      raiseRecord();
      applyStimulus(4'hD);
      applyStimulus(4'hE);
      Record = 1'b0;
      tick();
      tick();
      Mic_In    = 4'hF;
      Sample_En = 1'b1;
      expectRead("sim_oldA", 3'd2, 0, 4'h3);
      expectRead("sim_oldB", 3'd2, 1, 4'hB);
      tick();
      Sample_En = 1'b0;
      checkOutput("sim_doneA", 32'(doneA), 1);
      checkOutput("sim_countA", 32'(cntA), 3);
      checkOutput("sim_doneB", 32'(doneB), 1);
      checkOutput("sim_countB", 32'(cntB), 3);
      expectRead("sim_newA", 3'd2, 0, 4'hF);
      expectRead("sim_newB", 3'd2, 1, 4'hF);
      tick();

      // Re-arm from DONE with Count 5; a sub-cycle glitch is ignored
      raiseRecord();
      for (int v = 1; v <= 5; v++) applyStimulus(4'(v));
      dropRecord();
      checkOutput("take5_done", 32'(doneA), 1);
      checkOutput("take5_count", 32'(cntA), 5);
      Record = 1'b1;
      #2;
      Record = 1'b0;
      repeat (4) tick();
      checkOutput("glitch_done", 32'(doneA), 1);
      checkOutput("glitch_busy", 32'(busyA), 0);
      checkOutput("glitch_count", 32'(cntA), 5);
      Record = 1'b1;
      tick();
      tick();
      checkOutput("rearm_edge2_count", 32'(cntA), 5);
      checkOutput("rearm_edge2_done", 32'(doneA), 1);
      tick();
      checkOutput("rearm_edge3_busy", 32'(busyA), 1);
      checkOutput("rearm_edge3_done", 32'(doneA), 0);
      checkOutput("rearm_edge3_count", 32'(cntA), 0);

      // Reset mid-take, no clock edge needed
      applyStimulus(4'h3);
      applyStimulus(4'h4);
      checkOutput("mid_count", 32'(cntA), 2);
      #2;
      RST_N  = 1'b0;
      Record = 1'b0;
      #1;
      checkOutput("midrst_busy", 32'(busyA), 0);
      checkOutput("midrst_done", 32'(doneA), 0);
      checkOutput("midrst_count", 32'(cntA), 0);
      checkOutput("midrst_busyB", 32'(busyB), 0);
      checkOutput("midrst_rd", 32'(rdA), 0);
      tick();
      RST_N = 1'b1;
      tick();
      checkOutput("postrst_busy", 32'(busyA), 0);
      checkOutput("postrst_done", 32'(doneA), 0);
      expectRead("kept_A", 3'd1, 0, 4'h4);
      expectRead("kept_C", 3'd1, 2, 4'h4);
      tick();
      expectRead("oor_C6", 3'd6, 2, 4'h0);
      expectRead("inrange_A6", 3'd6, 0, 4'h7);
      tick();
      expectRead("oor_C7", 3'd7, 2, 4'h0);
      tick();

      for (int n = 0; n < 10 && readQ.size() > 0; n++) tick();
      if (readQ.size() > 0) checkOutput("read_drain", 32'(readQ.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wavetable_recorder.md
Name: wavetable_recorder

Overview:
- Parametrised successor to the single-bit 32-entry wavetable capture block.
- Captures SAMPLE_W-bit microphone samples into a DEPTH-entry wavetable on a sample strobe, gated by the Record button.
- Supports one-shot and loop (circular overwrite) modes, with status flags and a synchronous read port.
- Sits between the mic front-end and the wavetable playback/oscillator path.

Parameters:
SAMPLE_W, 1, bits per captured sample.
DEPTH, 32, wavetable entries; any value >= 2.
ADDR_W, $clog2(DEPTH), address width (derived).
LOOP, 0, 0 = one-shot (stop when full), 1 = circular overwrite until Record drops.

Ports:
CLK  in  1  system clock, all logic on rising edge.
RST_N  in  1  asynchronous active-low reset.
Record  in  1  asynchronous button level; high = record.
Mic_In  in  SAMPLE_W  sample data, synchronous to CLK.
Sample_En  in  1  one-cycle sample strobe, synchronous to CLK.
Rd_Addr  in  ADDR_W  playback read address.
Rd_Data  out  SAMPLE_W  mem[Rd_Addr], registered.
Busy  out  1  high while in REC.
Done  out  1  high in DONE state.
Wrapped  out  1  loop mode has overwritten at least once this take.
Count  out  ADDR_W+1  valid entries in the current take.

Behaviour:
- Reset: one clock, asynchronous and active-low. While RST_N is low:
  - State is IDLE.
  - Busy, Done and Wrapped are 0; Count, the write pointer, the synchroniser flops and Rd_Data are 0.
  - Memory contents are not reset; they are undefined until written.
- Record path: two-flop synchroniser, then an edge register. A rise on Record is acted on at the 3rd CLK edge after Record goes high; a fall likewise.
- FSM states: IDLE, REC, DONE.
  - IDLE -> REC on synchronised rising edge: write pointer := 0, Count := 0, Wrapped := 0, Done := 0.
  - DONE -> REC on the same rising edge, with the same clears. This starts a new take.
  - REC, on Sample_En: mem[wr_ptr] := Mic_In. Count increments, saturating at DEPTH. wr_ptr increments.
  - REC, write at wr_ptr = DEPTH-1, LOOP=0: the write happens, Count = DEPTH, state -> DONE on that edge.
  - REC, write at wr_ptr = DEPTH-1, LOOP=1: wr_ptr wraps to 0, Wrapped := 1, recording continues.
  - REC -> DONE on synchronised falling edge. Count holds the entries written, at most DEPTH.
  - Falling edge and Sample_En in the same cycle: the write is performed first, then DONE.
  - DONE holds all outputs until the next rising edge. IDLE is reachable only through reset.
- Sample_En outside REC is ignored. A Record rise while already in REC (glitch after the synchroniser) is ignored.
- Read port:
  - 1-cycle latency: Rd_Data at edge n+1 = mem[Rd_Addr sampled at edge n].
  - Reads are allowed in every state.
  - Read and write to the same address in the same cycle returns the old data (read-first).
  - Rd_Addr >= DEPTH (non-power-of-2 DEPTH) returns 0.
- Busy = (state == REC); Done = (state == DONE). Both are registered and glitch-free.
- Reset asserted mid-take: immediate return to IDLE, partial data left in memory, Count = 0.

Decomposition:
- Shared package wt_pkg:
  - State encoding constants: IDLE = 2'd0, REC = 2'd1, DONE = 2'd2.
  - Default SAMPLE_W and DEPTH, reused by the playback block.
- Natural sub-module: wt_sync_edge. It holds the 2-flop synchroniser plus rise/fall pulse generation, has an async active-low reset, and is reused for other buttons.
- The memory is inferred inline as a simple dual-port RAM.

Test Plan:
All scenarios use DEPTH=8 and SAMPLE_W=4 unless stated.
- Reset mid-record: RST_N low during a take -> Busy=0, Done=0, Count=0 immediately, with no clock edge needed.
- One-shot fill, LOOP=0: raise Record, then issue 10 Sample_En pulses with Mic_In = 1..10 -> DONE after the 8th write, Count=8, mem[0..7] = 1..8, writes 9 and 10 ignored.
- Early stop: raise Record, 3 writes (A, B, C), drop Record -> Done 3 cycles after the fall, Count=3, Rd_Addr=2 gives Rd_Data=C one cycle later.
- Loop mode, LOOP=1: 11 writes with values 1..11 then drop Record -> Wrapped=1, Count=8, mem = {9,10,11,4,5,6,7,8}.
- Simultaneous events: Sample_En coincident with the synchronised fall -> that sample is stored and Count includes it. A read of the address being written returns the old value.
- Re-arm: from DONE with Count=5, raise Record -> Count=0, Done=0, Busy=1 at the 3rd edge. A Record pulse of 1 cycle shorter than the synchroniser window, with no stable level, produces no state change.
